// File: rtl/cpu_pkg.sv
// Shared CPU observation types: the commit record seen by the tracer and the
// trace record/frame definitions used by commit_tracer.
package cpu_pkg;

    typedef struct packed {
        logic        valid;
        logic [15:0] pc;
        logic [15:0] instr;
        logic        rd_we;
        logic [2:0]  rd_addr;
        logic [15:0] rd_data;
    } commit_t;

    localparam logic [3:0] TRACE_SYNC = 4'hA;

    typedef struct packed {
        logic        ovf;
        logic [6:0]  seq;
        logic        rd_we;
        logic [2:0]  rd_addr;
        logic [15:0] pc;
        logic [15:0] instr;
        logic [15:0] rd_data;
    } trace_rec_t;

    typedef enum logic [2:0] {IDLE, HDR, PC, INSTR, DATA} trace_state_t;

    function automatic logic [15:0] trace_header(input trace_rec_t rec);
        return {TRACE_SYNC, rec.ovf, rec.rd_we, rec.rd_addr, rec.seq};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Synchronous first-word-fall-through FIFO; read data is the head entry
// whenever the FIFO is not empty. Push while full / pop while empty are ignored.
module trace_fifo #(
    parameter int unsigned WIDTH = 60,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_full,
    output logic             o_empty,
    output logic [AW:0]      o_level
);

    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             w_wr;
    logic             w_rd;

    assign o_full  = (r_level == FULL_LVL);
    assign o_empty = (r_level == '0);
    assign o_level = r_level;
    assign o_rdata = r_mem[r_rd_ptr];
    assign w_wr    = i_push && !o_full;
    assign w_rd    = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/commit_tracer.sv
// Captures CPU commit records into a FIFO and serializes each as a 4-word
// 16-bit frame (header, pc, instr, rd_data) on a valid/ready stream.
module commit_tracer
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 8,
    localparam int unsigned LW   = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  commit_t          commit,
    input  logic             trace_en,
    output logic             out_valid,
    output logic [15:0]      out_data,
    input  logic             out_ready,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [LW-1:0]    fifo_level
);

    trace_state_t     r_state;
    trace_state_t     w_next;
    trace_rec_t       r_hold;
    trace_rec_t       w_rec;
    trace_rec_t       w_rdata;
    logic [6:0]       r_seq;
    logic             r_ovf_pending;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             w_obs;
    logic             w_push;
    logic             w_drop;
    logic             w_pop;
    logic             w_adv;
    logic             w_full;
    logic             w_empty;

    assign w_obs  = commit.valid && trace_en;
    assign w_push = w_obs && !w_full;
    assign w_drop = w_obs && w_full;
    assign w_adv  = out_valid && out_ready;
    assign w_pop  = ((r_state == IDLE) || ((r_state == DATA) && w_adv)) && !w_empty;

    assign out_valid = (r_state != IDLE);
    assign drop_cnt  = r_drop_cnt;

    always_comb begin
        w_rec         = '0;
        w_rec.ovf     = r_ovf_pending;
        w_rec.seq     = r_seq;
        w_rec.rd_we   = commit.rd_we;
        w_rec.rd_addr = commit.rd_addr;
        w_rec.pc      = commit.pc;
        w_rec.instr   = commit.instr;
        w_rec.rd_data = commit.rd_data;
    end

    trace_fifo #(
        .WIDTH ($bits(trace_rec_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_push  (w_push),
        .i_wdata (w_rec),
        .i_pop   (w_pop),
        .o_rdata (w_rdata),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_level (fifo_level)
    );

    // A drop always wins over the clear so the next pushed record reports it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_seq         <= '0;
            r_ovf_pending <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_obs) r_seq <= r_seq + 1'b1;
            if (w_drop) begin
                r_ovf_pending <= 1'b1;
                if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
            end else if (w_push) begin
                r_ovf_pending <= 1'b0;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (!w_empty) w_next = HDR;
            HDR:     if (w_adv) w_next = PC;
            PC:      if (w_adv) w_next = INSTR;
            INSTR:   if (w_adv) w_next = DATA;
            DATA:    if (w_adv) w_next = w_empty ? IDLE : HDR;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            if (w_pop) r_hold <= w_rdata;
        end
    end

    always_comb begin
        out_data = '0;
        unique case (r_state)
            HDR:     out_data = trace_header(r_hold);
            PC:      out_data = r_hold.pc;
            INSTR:   out_data = r_hold.instr;
            DATA:    out_data = r_hold.rd_data;
            default: out_data = '0;
        endcase
    end

endmodule

// File: tb/tb_commit_tracer.sv
// Directed bench for commit_tracer with a word scoreboard filled at commit time.
module tb_commit_tracer;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    commit_t     commit;
    logic        trace_en;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic [7:0]  drop_cnt;
    logic [3:0]  fifo_level;

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [6:0]  m_seq = '0;
    logic        m_ovf = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data = '0;

    commit_tracer #(.DEPTH(8), .CNT_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .commit     (commit),
        .trace_en   (trace_en),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .drop_cnt   (drop_cnt),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one commit for one cycle; the caller sits at posedge+1.
    task automatic put(input logic [15:0] pc, input logic [15:0] instr, input logic we,
                       input logic [2:0] addr, input logic [15:0] data, input bit accepted);
        commit.valid   = 1'b1;
        commit.pc      = pc;
        commit.instr   = instr;
        commit.rd_we   = we;
        commit.rd_addr = addr;
        commit.rd_data = data;
        if (trace_en) begin
            if (accepted) begin
                exp_q.push_back({4'hA, m_ovf, we, addr, m_seq});
                exp_q.push_back(pc);
                exp_q.push_back(instr);
                exp_q.push_back(data);
                m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
            end
            m_seq = m_seq + 7'd1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        commit.valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_data", 32'(out_data), 32'(prev_data));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    assert (exp_q.size() != 0) else begin
                        failures++;
                        $error("FAIL unexpected_word: observed %h expected none", out_data);
                    end
                end else begin
                    check("sb_word", 32'(out_data), 32'(exp_q.pop_front()));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; commit = '0; trace_en = 1'b1; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        idle(2);

        // Single commit: header appears two cycles after the commit cycle.
        put(16'h0040, 16'h1234, 1'b1, 3'd3, 16'hBEEF, 1'b1);
        commit.valid = 1'b0;
        check("lat_n1_valid", 32'(out_valid), 32'd0);
        check("lat_n1_level", 32'(fifo_level), 32'd1);
        @(posedge clk); #1;
        check("lat_hdr_valid", 32'(out_valid), 32'd1);
        check("lat_hdr", 32'(out_data), 32'h0000_A580);
        check("lat_hdr_level", 32'(fifo_level), 32'd0);
        @(posedge clk); #1;
        check("lat_pc", 32'(out_data), 32'h0000_0040);
        @(posedge clk); #1;
        check("lat_instr", 32'(out_data), 32'h0000_1234);
        @(posedge clk); #1;
        check("lat_data", 32'(out_data), 32'h0000_BEEF);
        @(posedge clk); #1;
        check("lat_end_valid", 32'(out_valid), 32'd0);
        idle(2);

        // Back-pressure on the header for 5 cycles.
        out_ready = 1'b0;
        put(16'h0044, 16'h5678, 1'b0, 3'd5, 16'h0F0F, 1'b1);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_hdr", 32'(out_data), {16'h0, 4'hA, 1'b0, 1'b0, 3'd5, 7'd1});
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        idle(6);

        // Overflow: one frame stalled in the serializer, then DEPTH+3 commits.
        out_ready = 1'b0;
        put(16'h2000, 16'hA000, 1'b1, 3'd1, 16'h1111, 1'b1);
        idle(3);
        check("ovf_pre_level", 32'(fifo_level), 32'd0);
        for (int i = 0; i < 11; i++) begin
            put(16'h2100 + 16'(i), 16'hB000 + 16'(i), 1'b1, 3'(i), 16'h3000 + 16'(i), i < 8);
        end
        commit.valid = 1'b0;
        check("ovf_level", 32'(fifo_level), 32'd8);
        check("ovf_drop", 32'(drop_cnt), 32'd3);
        out_ready = 1'b1;
        for (int i = 0; i < 36; i++) begin
            check("b2b_valid", 32'(out_valid), 32'd1);
            @(posedge clk); #1;
        end
        check("b2b_end_valid", 32'(out_valid), 32'd0);
        put(16'h2200, 16'hC000, 1'b1, 3'd7, 16'h4444, 1'b1);
        idle(8);

        // Capture disabled: nothing observed, counters frozen.
        trace_en = 1'b0;
        for (int i = 0; i < 4; i++) put(16'h3000 + 16'(i), 16'hD000, 1'b1, 3'd2, 16'h5555, 1'b1);
        idle(8);
        check("dis_valid", 32'(out_valid), 32'd0);
        check("dis_level", 32'(fifo_level), 32'd0);
        check("dis_drop", 32'(drop_cnt), 32'd3);
        trace_en = 1'b1;
        put(16'h3100, 16'hE000, 1'b0, 3'd0, 16'h6666, 1'b1);
        idle(8);

        // Reset during word2 abandons the frame.
        put(16'h0400, 16'h7777, 1'b1, 3'd6, 16'h8888, 1'b1);
        commit.valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("rst_mid_word2", 32'(out_data), 32'h0000_7777);
        rst = 1'b1;
        exp_q.delete();
        m_seq = '0;
        m_ovf = 1'b0;
        @(posedge clk); #1;
        check("rstm_valid", 32'(out_valid), 32'd0);
        check("rstm_drop", 32'(drop_cnt), 32'd0);
        check("rstm_level", 32'(fifo_level), 32'd0);
        rst = 1'b0;
        idle(1);
        put(16'h0500, 16'h9999, 1'b1, 3'd2, 16'hAAAA, 1'b1);
        idle(1);
        check("rstm_hdr", 32'(out_data), {16'h0, 4'hA, 1'b0, 1'b1, 3'd2, 7'd0});
        idle(4);

        // Seq wrap: 129 more commits, the 129th frame since reset carries seq 0.
        for (int i = 0; i < 129; i++) begin
            put(16'h6000 + 16'(i), 16'h0100 + 16'(i), i[0], 3'(i), 16'(i * 3), 1'b1);
            idle(4);
        end

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
        check("final_level", 32'(fifo_level), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
